// File: rtl/serial_parity_rx.sv
// serial_parity_rx: receives start / data (LSB first) / parity / stop frames
// from a qualified bit stream, recomputes parity with a running XOR and
// presents the word with parity and framing status.
// Optional feature macro: PARITY_RX_ERR_COUNT_EN (saturating error counter).
// Handshake: serial_in is consumed only in cycles where in_valid=1; there is
// no backpressure. out_valid is a one-cycle strobe that qualifies data_out,
// parity_err and frame_err, which then hold until the next frame completes.
module serial_parity_rx #(
    parameter int WIDTH = 8,
    parameter bit ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy,
    output logic [7:0]       err_count
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start;
    logic               w_done;
    logic               w_parity_err;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_acc;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_out_valid;
    logic               r_parity_err;
    logic               r_frame_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; every transition needs a qualified bit.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && !serial_in) begin
                    w_state_next = S_DATA;
                    w_start      = 1'b1;
                end
            end
            S_DATA: begin
                if (in_valid && (r_cnt == LAST_BIT)) begin
                    w_state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (in_valid) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (in_valid) begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The accumulator already holds data XOR parity while in STOP.
    assign w_parity_err = r_acc ^ ODD;

    // Deserialiser: place data bit k at bit k, accumulate parity over data and parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
        end else if (w_start) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
        end else if (in_valid && (r_state == S_DATA)) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    r_shift[i] <= serial_in;
                end
            end
            r_acc <= r_acc ^ serial_in;
            if (r_cnt != LAST_BIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (in_valid && (r_state == S_PARITY)) begin
            r_acc <= r_acc ^ serial_in;
        end
    end

    // Result registers: word and status captured together on the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_out_valid <= w_done;
            if (w_done) begin
                r_data_out   <= r_shift;
                r_parity_err <= w_parity_err;
                r_frame_err  <= ~serial_in;
            end
        end
    end

`ifdef PARITY_RX_ERR_COUNT_EN
    logic [7:0] r_err_count;

    // Count completed frames with any error, holding at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_done && (w_parity_err || !serial_in) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    assign data_out   = r_data_out;
    assign out_valid  = r_out_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Testbench for serial_parity_rx: an even-parity and an odd-parity instance
// share one bit stream; each expected frame is queued when driven and
// checked when out_valid fires.
module tb_serial_parity_rx;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         serial_in;
  logic         in_valid;
  logic [W-1:0] e_data, o_data;
  logic         e_valid, o_valid;
  logic         e_perr, o_perr;
  logic         e_ferr, o_ferr;
  logic         e_busy, o_busy;
  logic [7:0]   e_cnt, o_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt_e = 0;
  int model_cnt_o = 0;
  int last_out = 0;
  int prev_out = 0;

  // {data, parity_err even, frame_err}
  logic [W+1:0] exp_q[$];
  int           exp_t_q[$];

`ifdef PARITY_RX_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  serial_parity_rx #(.WIDTH(W), .ODD(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .in_valid(in_valid),
    .data_out(e_data), .out_valid(e_valid), .parity_err(e_perr),
    .frame_err(e_ferr), .busy(e_busy), .err_count(e_cnt)
  );

  serial_parity_rx #(.WIDTH(W), .ODD(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .in_valid(in_valid),
    .data_out(o_data), .out_valid(o_valid), .parity_err(o_perr),
    .frame_err(o_ferr), .busy(o_busy), .err_count(o_cnt)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (e_valid || o_valid)) begin
      check("out_valid_pair", {31'd0, o_valid}, {31'd0, e_valid});
      check("out_valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        logic [W+1:0] ex;
        int           t;
        ex = exp_q.pop_front();
        t  = exp_t_q.pop_front();
        if (ex[1] | ex[0]) model_cnt_e = sat_inc(model_cnt_e);
        if (~ex[1] | ex[0]) model_cnt_o = sat_inc(model_cnt_o);
        check("latency", cyc, t);
        check("data_even", {24'd0, e_data}, {24'd0, ex[W+1:2]});
        check("data_odd", {24'd0, o_data}, {24'd0, ex[W+1:2]});
        check("perr_even", {31'd0, e_perr}, {31'd0, ex[1]});
        check("perr_odd", {31'd0, o_perr}, {31'd0, ~ex[1]});
        check("ferr", {30'd0, e_ferr, o_ferr}, {30'd0, ex[0], ex[0]});
        check("err_count_even", {24'd0, e_cnt}, CNT_EN ? model_cnt_e : 0);
        check("err_count_odd", {24'd0, o_cnt}, CNT_EN ? model_cnt_o : 0);
        prev_out = last_out;
        last_out = cyc;
      end
    end
  end

  // driver tasks
  task automatic drive(input logic b);
    @(negedge clk);
    serial_in = b;
    in_valid  = 1'b1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      serial_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop,
                            input int gap_at, input int gap_len);
    int t_start;
    exp_q.push_back({d, (^d) ^ p, ~stop});
    drive(1'b0);
    t_start = cyc + 1;
    exp_t_q.push_back(t_start + W + 2 + gap_len);
    for (int k = 0; k < W; k++) begin
      if (k == gap_at) gap(gap_len);
      drive(d[k]);
      if (k == 0) check("busy_in_frame", {31'd0, e_busy}, 32'd1);
    end
    drive(p);
    drive(stop);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {e_data, e_valid, e_perr, e_ferr, e_busy, e_cnt}, 32'd0);
    check(tag, {o_data, o_valid, o_perr, o_ferr, o_busy, o_cnt}, 32'd0);
  endtask

  // directed sequence
  initial begin
    logic [W-1:0] d;
    rst_n     = 1'b0;
    serial_in = 1'b1;
    in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // idle line ones: nothing may happen
    for (int i = 0; i < 5; i++) drive(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("idle_busy", {31'd0, e_busy}, 32'd0);
    check("idle_no_out", {24'd0, e_data}, 32'd0);

    // good even frame, then held outputs
    send_frame(8'hA5, 1'b0, 1'b1, -1, 0);
    drain();
    check("busy_after_frame", {31'd0, e_busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("data_held", {24'd0, e_data}, 32'h0000_00A5);

    // bad parity for even
    send_frame(8'hA5, 1'b1, 1'b1, -1, 0);
    drain();

    // 0x01 parity 0: odd-parity good, even bad; stop bit 0 -> frame error
    send_frame(8'h01, 1'b0, 1'b0, -1, 0);
    drain();
    check("busy_after_ferr", {31'd0, e_busy}, 32'd0);

    // 0x3C with a 3-cycle gap mid-data
    send_frame(8'h3C, 1'b0, 1'b1, 4, 3);
    drain();

    // abort after 4 data bits via reset
    drive(1'b0);
    for (int k = 0; k < 4; k++) drive(1'(k & 1));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_cnt_e = 0;
    model_cnt_o = 0;
    #1;
    check_reset_outputs("reset_mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h7E, 1'b0, 1'b1, -1, 0);
    drain();
    check("data_after_abort", {24'd0, e_data}, 32'h0000_007E);

    // back-to-back frames
    send_frame(8'h11, 1'b0, 1'b1, -1, 0);
    send_frame(8'h22, 1'b0, 1'b1, -1, 0);
    drain();
    check("b2b_spacing", last_out - prev_out, 32'd11);

    // many bad-parity frames for the even instance (counter saturation)
    for (int n = 0; n < 260; n++) begin
      d = W'($urandom_range(0, 255));
      send_frame(d, ~(^d), 1'b1, -1, 0);
    end
    drain();
    check("err_count_final_even", {24'd0, e_cnt}, CNT_EN ? 32'd255 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial frame receiver with parity check: the receiving end of the team's XOR/parity datapath. It deserialises a qualified bit stream (start bit, data LSB-first, parity bit, stop bit) and recomputes parity with an XOR accumulator. It delivers the parallel word with parity and framing status. It sits between a bit-level source (serial generator or bench driver) and any parallel consumer in the lab exercises.

## Interface

Parameters:
- `WIDTH`, default 8: data bits per frame, legal range 1..16.
- `ODD`, default 0: 0 = even parity (data XOR parity == 0); 1 = odd parity (data XOR parity == 1).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `serial_in`, input, 1: current line bit; sampled only when `in_valid`=1.
- `in_valid`, input, 1: qualifies `serial_in` for this cycle.
- `data_out`, output, WIDTH: last received word; held until the next frame completes.
- `out_valid`, output, 1: one-cycle pulse when a frame completes.
- `parity_err`, output, 1: parity mismatch for the frame flagged by `out_valid`; valid with `out_valid`, held after it.
- `frame_err`, output, 1: stop bit sampled as 0; valid with `out_valid`, held after it.
- `busy`, output, 1: high in every state except IDLE.
- `err_count`, output, 8: error counter (see Configuration).

## Operation

- FSM states and transitions:
  - IDLE -> DATA on a valid bit with value 0 (start bit). Valid 1s in IDLE are idle line and are ignored.
  - DATA -> PARITY after WIDTH valid bits.
  - PARITY -> STOP after 1 valid bit.
  - STOP -> IDLE after 1 valid bit. This transition produces the result.
- Cycles with `in_valid`=0 hold all state: no advance, no timeout.
- DATA stage:
  - Data bit k (k = 0..WIDTH-1) is shifted into bit k of an internal shift register (LSB first).
  - A 1-bit accumulator XORs each data bit. It is cleared on the start bit.
  - A bit counter is sized ceil(log2(WIDTH+1)). It counts 0..WIDTH-1 and does not wrap past WIDTH.
- PARITY stage: the sampled parity bit is XORed into the accumulator. `parity_err` = accumulator XOR ODD.
- STOP stage:
  - `frame_err` = ~stop bit.
  - The word, `parity_err` and `frame_err` are registered together and `out_valid` pulses.
  - On a frame error the FSM still returns to IDLE.
- Reset values (async on `rst_n`=0):
  - state = IDLE.
  - `data_out` = 0, `out_valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0, `err_count` = 0.
  - Shift register, counter and accumulator = 0.
- Reset mid-frame: the partial frame is discarded and no `out_valid` is produced. The first valid 0 after `rst_n` rises starts a new frame.
- Back-to-back frames: the start bit of the next frame is accepted in the cycle immediately after the stop bit.

## Timing

- `out_valid` rises on the clock edge that samples the valid stop bit (registered output). It is high for exactly 1 cycle.
- Minimum frame latency is WIDTH+3 valid cycles from the start bit to the `out_valid` edge.
- `data_out`, `parity_err` and `frame_err` change only on that same edge.
- `busy` rises on the edge after the start bit is sampled and falls on the `out_valid` edge.
- No combinational path from inputs to outputs.

## Configuration

- Macro `PARITY_RX_ERR_COUNT_EN`:
  - Defined: `err_count` is an 8-bit counter. It increments by 1 on each `out_valid` with (`parity_err` | `frame_err`) = 1, saturates at 255 (no wrap), and clears only on reset.
  - Undefined: the counter logic is not compiled and `err_count` is tied to 8'd0.
- Port list is identical in both builds.

## Test plan

- Even, WIDTH=8: send start 0, data 0xA5 LSB-first, parity 0, stop 1, with `in_valid`=1 every cycle -> `data_out`=0xA5, `parity_err`=0, `frame_err`=0, single `out_valid` pulse 11 cycles after the start bit.
- Same frame with parity 1 -> `parity_err`=1, `data_out`=0xA5. With the macro defined, `err_count`=1; undefined, 0.
- ODD=1, data 0x01, parity 0 -> `parity_err`=0. Stop bit 0 -> `frame_err`=1 and FSM back in IDLE (`busy`=0).
- Frame 0x3C with `in_valid` deasserted for 3 cycles mid-data -> same result as the gapless frame, `out_valid` delayed by 3 cycles. Idle 1s before the start bit produce no activity.
- Pulse `rst_n` low after 4 data bits, then send a full frame 0x7E -> no `out_valid` for the aborted frame, `data_out`=0x7E afterwards. Two back-to-back frames 0x11, 0x22 -> two pulses 11 cycles apart.
- With the macro defined, 260 frames with bad parity -> `err_count` saturates at 255.
